// File: rtl/tree_result_collector_if.sv
// tree_result_collector_if: issue/tree/output handshake bundle shared by the collector and its environment
interface tree_result_collector_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  issue_valid;
    logic                  issue_last;
    logic                  issue_ready;
    logic [DATA_WIDTH-1:0] tree_result;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic [15:0]           rows_done;
    logic                  ovf_err;
    logic                  row_len_err;
    modport slave (
        input  issue_valid, issue_last, tree_result, out_ready,
        output issue_ready, out_valid, out_data, out_last, rows_done, ovf_err, row_len_err
    );
    modport master (
        output issue_valid, issue_last, tree_result, out_ready,
        input  issue_ready, out_valid, out_data, out_last, rows_done, ovf_err, row_len_err
    );
endinterface

// File: rtl/tree_result_collector.sv
// tree_result_collector: adder-tree consumer with valid/last delay line, result FIFO and credit backpressure; optional row-length checker under ROW_CHECK_EN
module tree_result_collector #(
    parameter int DATA_WIDTH   = 16,
    parameter int TREE_LATENCY = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int ROW_LEN      = 128
) (
    input logic clk,
    input logic rst,
    tree_result_collector_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [TREE_LATENCY-1:0] r_vld;
    logic [TREE_LATENCY-1:0] r_lst;
    logic [DATA_WIDTH:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           r_infl;
    logic [DATA_WIDTH:0]     r_hold;
    logic [15:0]             r_rows;
    logic                    r_ovf;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_push_last;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_wr;
    logic [CW:0]             w_credit;
    logic [DATA_WIDTH:0]     w_head;

    // credit counts stored entries plus sums still travelling through the tree
    assign w_credit        = {1'b0, r_cnt} + {1'b0, r_infl};
    assign bus.issue_ready = w_credit < (CW+1)'(FIFO_DEPTH);
    assign w_accept        = bus.issue_valid & bus.issue_ready;
    assign w_push          = r_vld[TREE_LATENCY-1];
    assign w_push_last     = r_lst[TREE_LATENCY-1];
    assign w_full          = r_cnt == CW'(FIFO_DEPTH);
    assign bus.out_valid   = r_cnt != '0;
    assign w_pop           = bus.out_valid & bus.out_ready;
    assign w_wr            = w_push & (~w_full | w_pop);
    assign w_head          = bus.out_valid ? r_mem[r_rd_ptr] : r_hold;
    assign bus.out_data    = w_head[DATA_WIDTH-1:0];
    assign bus.out_last    = w_head[DATA_WIDTH];
    assign bus.rows_done   = r_rows;
    assign bus.ovf_err     = r_ovf;

    // valid/last delay line mirroring the adder tree latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld[0] <= w_accept;
            r_lst[0] <= bus.issue_last & w_accept;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    // result storage; contents need no reset since occupancy is tracked by r_cnt
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {w_push_last, bus.tree_result};
    end

    // pointers, occupancy, in-flight credit, row counter and overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_infl   <= '0;
            r_hold   <= '0;
            r_rows   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_hold   <= w_head;
                if (w_head[DATA_WIDTH])
                    r_rows <= r_rows + 16'd1;
            end
            r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_pop);
            r_infl <= r_infl + CW'(w_accept) - CW'(w_push);
            if (w_push & w_full & ~w_pop)
                r_ovf <= 1'b1;
        end
    end

`ifdef ROW_CHECK_EN
    logic [15:0] r_elem;
    logic        r_rle;
    logic [15:0] w_elem_inc;

    assign w_elem_inc      = r_elem + 16'd1;
    assign bus.row_len_err = r_rle;

    // row length checker: a last tag must land exactly on element ROW_LEN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elem <= '0;
            r_rle  <= 1'b0;
        end else if (w_push) begin
            if (w_push_last) begin
                r_elem <= '0;
                if (w_elem_inc != 16'(ROW_LEN))
                    r_rle <= 1'b1;
            end else if (w_elem_inc >= 16'(ROW_LEN)) begin
                r_elem <= 16'(ROW_LEN);
                r_rle  <= 1'b1;
            end else begin
                r_elem <= w_elem_inc;
            end
        end
    end
`else
    assign bus.row_len_err = 1'b0 & |ROW_LEN;
`endif
endmodule

// File: tb/tb_tree_result_collector.sv
// tb_tree_result_collector: directed self-checking bench for tree_result_collector
module tb_tree_result_collector;
    localparam int DW = 16;
    localparam int L  = 8;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] issue_data;
    logic [DW-1:0] pipe [L];
    int            checks = 0;
    int            failures = 0;
    int            acc, idx, ex, first_c, last_c;
    logic          a, ir_ok, ov_seen;

    always #5 clk = ~clk;

    tree_result_collector_if #(.DATA_WIDTH(DW)) bus ();

    tree_result_collector #(
        .DATA_WIDTH(DW), .TREE_LATENCY(L), .FIFO_DEPTH(D), .ROW_LEN(128)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // adder tree stand-in: the issued value emerges L edges later
    always @(posedge clk) begin
        pipe[0] <= issue_data;
        for (int i = 1; i < L; i++)
            pipe[i] <= pipe[i-1];
    end
    assign bus.tree_result = pipe[L-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        assert (got === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp_v);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic send_row(input int n);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.issue_valid = 1'b1;
            bus.issue_last  = (i == n - 1);
            issue_data      = DW'(i);
            step;
        end
        bus.issue_valid = 1'b0;
        bus.issue_last  = 1'b0;
        repeat (L + 4) step;
    endtask

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_last  = 1'b0;
        bus.out_ready   = 1'b0;
        issue_data      = '0;
        rst             = 1'b1;
        repeat (3) step;
        rst = 1'b0;
        step;
        chk("rst_issue_ready", bus.issue_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_rows_done", bus.rows_done, 0);
        chk("rst_ovf_err", bus.ovf_err, 0);
        chk("rst_row_len_err", bus.row_len_err, 0);

        bus.issue_valid = 1'b1;
        bus.issue_last  = 1'b1;
        issue_data      = 16'h3F80;
        step;
        bus.issue_valid = 1'b0;
        bus.issue_last  = 1'b0;
        issue_data      = '0;
        chk("single_lat0", bus.out_valid, 0);
        for (int k = 1; k <= L; k++) begin
            step;
            chk($sformatf("single_lat%0d", k), bus.out_valid, k == L);
        end
        chk("single_data", bus.out_data, 16'h3F80);
        chk("single_last", bus.out_last, 1);
        bus.out_ready = 1'b1;
        step;
        bus.out_ready = 1'b0;
        chk("single_rows", bus.rows_done, 1);
        chk("single_empty", bus.out_valid, 0);
        chk("single_hold_data", bus.out_data, 16'h3F80);
        chk("single_hold_last", bus.out_last, 1);

        acc = 0;
        bus.issue_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            issue_data = DW'(acc);
            a = bus.issue_ready;
            step;
            if (a) acc++;
        end
        bus.issue_valid = 1'b0;
        chk("bp_accepts", acc, 16);
        chk("bp_ready_low", bus.issue_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_pop%0d", i), bus.out_data, i);
            step;
        end
        bus.out_ready = 1'b0;
        acc = 0;
        bus.issue_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            issue_data = DW'(16 + acc);
            a = bus.issue_ready;
            step;
            if (a) acc++;
        end
        bus.issue_valid = 1'b0;
        chk("bp_accepts2", acc, 8);
        chk("bp_ready_low2", bus.issue_ready, 0);
        chk("bp_ovf", bus.ovf_err, 0);
        bus.out_ready = 1'b1;
        for (int i = 8; i < 24; i++) begin
            chk($sformatf("bp_drain%0d", i), bus.out_data, i);
            step;
        end
        bus.out_ready = 1'b0;
        chk("bp_drained", bus.out_valid, 0);
        chk("bp_ready_back", bus.issue_ready, 1);

        bus.out_ready = 1'b1;
        idx = 0; ex = 0; ir_ok = 1'b1; first_c = -1; last_c = -1;
        for (int c = 0; c < 160; c++) begin
            bus.issue_valid = idx < 128;
            bus.issue_last  = idx == 127;
            issue_data      = DW'(idx);
            if (!bus.issue_ready) ir_ok = 1'b0;
            if (bus.out_valid) begin
                chk($sformatf("stream_data%0d", ex), bus.out_data, ex);
                chk($sformatf("stream_last%0d", ex), bus.out_last, ex == 127);
                if (first_c < 0) first_c = c;
                last_c = c;
                ex++;
            end
            a = bus.issue_valid & bus.issue_ready;
            step;
            if (a) idx++;
        end
        bus.issue_valid = 1'b0;
        bus.issue_last  = 1'b0;
        bus.out_ready   = 1'b0;
        chk("stream_count", ex, 128);
        chk("stream_rate", last_c - first_c, 127);
        chk("stream_ready", ir_ok, 1);
        chk("stream_rows", bus.rows_done, 2);

        acc = 0;
        bus.issue_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            issue_data = DW'(200 + acc);
            a = bus.issue_ready;
            step;
            if (a) acc++;
        end
        bus.issue_valid = 1'b0;
        chk("full_accepts", acc, 16);
        chk("full_head", bus.out_data, 200);
        chk("full_ready", bus.issue_ready, 0);
        bus.out_ready = 1'b1;
        step;
        bus.out_ready = 1'b0;
        chk("full_freed_ready", bus.issue_ready, 1);
        chk("full_head2", bus.out_data, 201);
        bus.issue_valid = 1'b1;
        issue_data      = 16'd216;
        step;
        bus.issue_valid = 1'b0;
        chk("full_credit_used", bus.issue_ready, 0);
        repeat (L - 1) step;
        chk("full_pre_pushpop", bus.out_data, 201);
        bus.out_ready = 1'b1;
        step;
        bus.out_ready = 1'b0;
        chk("full_pushpop_head", bus.out_data, 202);
        chk("full_pushpop_ovf", bus.ovf_err, 0);
        chk("full_pushpop_ready", bus.issue_ready, 1);
        bus.out_ready = 1'b1;
        for (int i = 202; i <= 216; i++) begin
            chk($sformatf("full_drain%0d", i), bus.out_data, i);
            step;
        end
        bus.out_ready = 1'b0;
        chk("full_drained", bus.out_valid, 0);

        bus.issue_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            issue_data = DW'(300 + c);
            step;
        end
        bus.issue_valid = 1'b0;
        repeat (3) step;
        chk("rmf_pre_valid", bus.out_valid, 1);
        chk("rmf_pre_data", bus.out_data, 300);
        chk("rmf_pre_ready", bus.issue_ready, 1);
        #1 rst = 1'b1;
        #1;
        chk("rmf_out_valid", bus.out_valid, 0);
        chk("rmf_issue_ready", bus.issue_ready, 1);
        step;
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) ov_seen = 1'b1;
            step;
        end
        chk("rmf_no_push", ov_seen, 0);
        chk("rmf_rows", bus.rows_done, 0);
        chk("rmf_ready", bus.issue_ready, 1);

        do_reset;
        send_row(127);
`ifdef ROW_CHECK_EN
        chk("row127_err", bus.row_len_err, 1);
`else
        chk("row127_err", bus.row_len_err, 0);
`endif
        chk("row127_rows", bus.rows_done, 1);
        do_reset;
        send_row(128);
        chk("row128_err", bus.row_len_err, 0);
        chk("row128_rows", bus.rows_done, 1);
        chk("row128_ovf", bus.ovf_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
